// File: rtl/median_win_seq_if.sv
// rtl/median_win_seq_if.sv - signal bundle for the median window sequencer
// Groups the pixel input stream (IN_*), the median engine handshake (MED_*)
// and the filtered output (OUT_*).
//   slave  : sequencer view
//   master : environment view (pixel source, median engine, output sink)

interface median_win_seq_if #(
    parameter int W = 8
);
    logic [W-1:0] IN_DATA;
    logic         IN_VALID;
    logic         IN_SOF;
    logic         IN_READY;
    logic [W-1:0] MED_DI;
    logic         MED_DSI;
    logic [W-1:0] MED_DO;
    logic         MED_DSO;
    logic [W-1:0] OUT_DATA;
    logic         OUT_VALID;
    logic         OUT_LAST;

    modport slave (
        input  IN_DATA, IN_VALID, IN_SOF, MED_DO, MED_DSO,
        output IN_READY, MED_DI, MED_DSI, OUT_DATA, OUT_VALID, OUT_LAST
    );

    modport master (
        output IN_DATA, IN_VALID, IN_SOF, MED_DO, MED_DSO,
        input  IN_READY, MED_DI, MED_DSI, OUT_DATA, OUT_VALID, OUT_LAST
    );
endinterface

// File: rtl/median_win_seq.sv
// rtl/median_win_seq.sv - 3x3 median filter sequencer around a shared 9-sample median engine
// Ports:
//   CLK  - clock, all logic on the rising edge
//   nRST - asynchronous active-low reset, shared with the median engine
//   bus  - slave view of median_win_seq_if:
//          IN_DATA/IN_VALID/IN_SOF/IN_READY  raster pixel input
//          MED_DI/MED_DSI                    samples to the engine
//          MED_DO/MED_DSO                    engine result and done strobe
//          OUT_DATA/OUT_VALID/OUT_LAST       filtered pixel, one-cycle pulse

module median_win_seq #(
    parameter int W     = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic            CLK,
    input  logic            nRST,
    median_win_seq_if.slave bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        LOAD   = 2'd1,
        WAIT   = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [3:0]     ld_cnt_q, ld_cnt_d;
    logic           last_q, last_d;
    logic [W-1:0]   out_data_q, out_data_d;

    // Line buffers: lb0 holds the previous line, lb1 the one before it.
    logic [W-1:0]   lb0_q [IMG_W];
    logic [W-1:0]   lb1_q [IMG_W];
    // Window stored row-major: index = row*3 + col, row 0 is the top line.
    logic [W-1:0]   win_q [9];
    logic [W-1:0]   win_d [9];

    logic           accept;
    logic [RW-1:0]  eff_row;
    logic [CW-1:0]  eff_col;
    logic           win_full;
    logic           at_end;

    // SOF forces the pixel to (0,0) irrespective of the running counters.
    assign accept   = bus.IN_VALID && (state_q == ACCEPT);
    assign eff_row  = bus.IN_SOF ? '0 : row_q;
    assign eff_col  = bus.IN_SOF ? '0 : col_q;
    assign win_full = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
    assign at_end   = (eff_row == RW'(IMG_H - 1)) && (eff_col == CW'(IMG_W - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCEPT: if (accept && win_full)  state_d = LOAD;
            LOAD:   if (ld_cnt_q == 4'd8)    state_d = WAIT;
            WAIT:   if (bus.MED_DSO)         state_d = EMIT;
            EMIT:                            state_d = ACCEPT;
            default:                         state_d = ACCEPT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.IN_READY  = (state_q == ACCEPT);
        bus.MED_DSI   = (state_q == LOAD);
        bus.MED_DI    = '0;
        if (state_q == LOAD) begin
            bus.MED_DI = win_q[ld_cnt_q];
        end
        bus.OUT_VALID = (state_q == EMIT);
        bus.OUT_LAST  = (state_q == EMIT) && last_q;
        bus.OUT_DATA  = out_data_q;
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        ld_cnt_d   = '0;

        if (accept) begin
            last_d = at_end;
            if (at_end) begin
                row_d = '0;
                col_d = '0;
            end else if (eff_col == CW'(IMG_W - 1)) begin
                row_d = eff_row + RW'(1);
                col_d = '0;
            end else begin
                row_d = eff_row;
                col_d = eff_col + CW'(1);
            end
        end

        if (state_q == LOAD && ld_cnt_q != 4'd8) begin
            ld_cnt_d = ld_cnt_q + 4'd1;
        end

        if (state_q == WAIT && bus.MED_DSO) begin
            out_data_d = bus.MED_DO;
        end
    end

    // New right column, top to bottom: two lines ago, previous line, incoming pixel.
    always_comb begin
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = lb1_q[eff_col];
        win_d[3] = win_q[4];
        win_d[4] = win_q[5];
        win_d[5] = lb0_q[eff_col];
        win_d[6] = win_q[7];
        win_d[7] = win_q[8];
        win_d[8] = bus.IN_DATA;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            row_q      <= '0;
            col_q      <= '0;
            ld_cnt_q   <= '0;
            last_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            ld_cnt_q   <= ld_cnt_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
        end
    end

    // Pixel storage is refilled before use in every frame, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            lb1_q[eff_col] <= lb0_q[eff_col];
            lb0_q[eff_col] <= bus.IN_DATA;
            win_q          <= win_d;
        end
    end

endmodule

// File: doc/median_win_seq.md
Name: median_win_seq

Overview:
- Sequencer that computes a 3x3 median filter over a raster pixel stream using one shared 9-sample median engine (W-bit, P=9).
- Keeps two line buffers and a 3x3 window.
- For every interior pixel, streams the 9 window samples into the engine, waits for its done strobe, and emits the result.
- Sits between the video input path and the median engine. The engine's DI/DSI/DO/DSO are driven and observed through this block's MED_* ports.

Parameters:
- W, 8, pixel width in bits.
- IMG_W, 640, pixels per line (>=3).
- IMG_H, 480, lines per frame (>=3).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- nRST  in  1  asynchronous active-low reset; shared with the median engine.
- IN_DATA  in  W  input pixel, raster order.
- IN_VALID  in  1  IN_DATA valid.
- IN_SOF  in  1  qualifies IN_DATA as pixel (0,0) of a new frame; sampled only with IN_VALID.
- IN_READY  out  1  block accepts a pixel this cycle.
- MED_DI  out  W  sample to engine.
- MED_DSI  out  1  sample strobe to engine.
- MED_DO  in  W  engine result.
- MED_DSO  in  1  engine done strobe.
- OUT_DATA  out  W  filtered pixel, registered.
- OUT_VALID  out  1  one-cycle pulse, OUT_DATA valid.
- OUT_LAST  out  1  with OUT_VALID, marks last output of the frame.

Behaviour:
- Reset (async, nRST=0):
  - state=ACCEPT; row=col=0; ld_cnt=0.
  - IN_READY=1, MED_DSI=0, MED_DI=0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0.
  - Line buffers and window registers are not reset; their contents are don't-care until refilled.
- Accept: a pixel is accepted when IN_VALID && IN_READY. IN_VALID while IN_READY=0 is ignored; the source holds its data.
- On accept at (row,col):
  - Window shifts left by one column. The new right column, top to bottom, is {lb1[col], lb0[col], IN_DATA}.
  - lb1[col] <= lb0[col]; lb0[col] <= IN_DATA.
  - col increments; it wraps to 0 at IMG_W-1 and row increments. At the last pixel of the frame (row IMG_H-1, col IMG_W-1), row and col both wrap to 0.
  - If IN_SOF=1 on the accept, the pixel is treated as (0,0) regardless of the current counters; a partial frame is abandoned.
- Job trigger: the window is complete when row>=2 && col>=2 at the accepted pixel. Its median is output pixel (row-1,col-1). Border pixels produce no output, giving (IMG_W-2)*(IMG_H-2) outputs per frame.
- State machine:
  - ACCEPT: IN_READY=1. On accept with a complete window -> LOAD. Otherwise stay.
  - LOAD: IN_READY=0, MED_DSI=1 for exactly 9 consecutive cycles.
    - MED_DI order is window[0][0..2], window[1][0..2], window[2][0..2] (top row left to right first).
    - ld_cnt counts 0..8; after ld_cnt=8 -> WAIT.
  - WAIT: MED_DSI=0, IN_READY=0. MED_DSO is sampled only in this state. On MED_DSO=1, OUT_DATA<=MED_DO -> EMIT. No timeout.
  - EMIT: OUT_VALID=1 for one cycle. OUT_LAST=1 if the job was the frame's last pixel. IN_READY=0. -> ACCEPT.
- Latency: first LOAD cycle is the cycle after the accept. OUT_VALID is asserted the cycle after MED_DSO is seen. IN_READY returns to 1 the cycle after EMIT.
- MED_DSO outside WAIT is ignored; the engine may glitch it while idle.
- Reset mid-job (any state): immediate return to reset values. The engine is reset by the same nRST; no partial result is emitted.
- IN_SOF during LOAD/WAIT/EMIT cannot occur on an accept (IN_READY=0). It takes effect on the next accept.
- Widths: row is ceil(log2(IMG_H)) bits, col is ceil(log2(IMG_W)) bits; no arithmetic overflow. Line buffers are IMG_W x W each.

Test Plan:
- IMG_W=4, IMG_H=3, pixels 1..12 with SOF on the first, IN_VALID held high -> exactly 2 outputs: 6 then 7. OUT_LAST=1 only on 7. No pixel dropped (12 accepts counted).
- Same frame, IN_VALID toggled randomly -> identical outputs. IN_READY=0 from the LOAD entry through EMIT. MED_DSI high for exactly 9 cycles per job, in the specified sample order.
- IMG_W=5, IMG_H=5, all pixels 50 except centre 255 -> 9 outputs, all 50. Salt noise is removed.
- Engine model asserts MED_DSO in idle and with delays of 1, 10 and 20 cycles -> spurious DSO ignored. OUT_VALID exactly one cycle after each in-WAIT DSO.
- Mid-frame IN_SOF on pixel 7 of a 4x3 frame, then a full frame of 1..12 -> no outputs from the abandoned frame's stale windows; outputs 6, 7 from the new frame.
- nRST pulsed low during WAIT -> all outputs at reset values asynchronously. No OUT_VALID for that job. The next full frame gives correct results.
